// File: rtl/m10k_row_arbiter_if.sv
// Bundle between the two row-memory requesters, the round-robin arbiter and the single M10K port.
// The requester/host side uses the master modport and the arbiter uses the slave modport.
interface m10k_row_arbiter_if #(
    parameter int DATA_LEN     = 32,
    parameter int N            = 8,
    parameter int ADDRESS_SIZE = 4
);
    logic                      i_req0;
    logic                      i_req1;
    logic                      i_we0;
    logic                      i_we1;
    logic [ADDRESS_SIZE-1:0]   i_addr0;
    logic [ADDRESS_SIZE-1:0]   i_addr1;
    logic [DATA_LEN*N-1:0]     i_wdata0;
    logic [DATA_LEN*N-1:0]     i_wdata1;
    logic                      i_lock0;
    logic                      i_lock1;
    logic                      o_gnt0;
    logic                      o_gnt1;
    logic                      o_rvalid0;
    logic                      o_rvalid1;
    logic [DATA_LEN*N-1:0]     o_rdata;
    logic [ADDRESS_SIZE-1:0]   o_mem_address;
    logic                      o_mem_wr_en;
    logic [DATA_LEN*N-1:0]     o_mem_write_data;
    logic [DATA_LEN*N-1:0]     i_mem_read_data;
    logic [1:0]                o_owner;

    modport slave (
        input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
        input  i_wdata0, i_wdata1, i_lock0, i_lock1, i_mem_read_data,
        output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata,
        output o_mem_address, o_mem_wr_en, o_mem_write_data, o_owner
    );

    modport master (
        output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
        output i_wdata0, i_wdata1, i_lock0, i_lock1, i_mem_read_data,
        input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata,
        input  o_mem_address, o_mem_wr_en, o_mem_write_data, o_owner
    );
endinterface

// File: rtl/m10k_row_arbiter.sv
// Round-robin arbiter sharing one 16-row M10K port between the row engine (side 0) and the host port (side 1).
// Define ROW_ARB_LOCK_EN to let a requester keep ownership of the port while its lock input is held.
module m10k_row_arbiter #(
    parameter int DATA_LEN     = 32,
    parameter int N            = 8,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    m10k_row_arbiter_if.slave    bus
);
    localparam int ROW_W = DATA_LEN * N;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } ownerState_e;

    ownerState_e               state_q, state_d;
    logic                      rrPtr_q, rrPtr_d;
    logic [ADDRESS_SIZE-1:0]   addr_q;
    logic                      rvalid0_q, rvalid1_q;
    logic                      gnt0, gnt1;
    logic                      lock0, lock1;
    logic [ADDRESS_SIZE-1:0]   memAddr;
    logic [ROW_W-1:0]          memWdata;

`ifdef ROW_ARB_LOCK_EN
    assign lock0 = bus.i_lock0;
    assign lock1 = bus.i_lock1;
`else
    assign lock0 = 1'b0;
    assign lock1 = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches the memory while i_rstn is low.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        rrPtr_d = rrPtr_q;
        if (i_rstn) begin
            case (state_q)
                ARB: begin
                    if (bus.i_req0 && (!bus.i_req1 || !rrPtr_q)) begin
                        gnt0    = 1'b1;
                        rrPtr_d = 1'b1;
                        if (lock0) state_d = OWN0;
                    end else if (bus.i_req1) begin
                        gnt1    = 1'b1;
                        rrPtr_d = 1'b0;
                        if (lock1) state_d = OWN1;
                    end
                end
                OWN0: begin
                    gnt0 = bus.i_req0;
                    if (!bus.i_req0 || !lock0) begin
                        state_d = ARB;
                        rrPtr_d = 1'b1;
                    end
                end
                OWN1: begin
                    gnt1 = bus.i_req1;
                    if (!bus.i_req1 || !lock1) begin
                        state_d = ARB;
                        rrPtr_d = 1'b0;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    // With no grant the port keeps the last address, so the memory just repeats a harmless read.
    always_comb begin
        memAddr  = addr_q;
        memWdata = bus.i_wdata0;
        if (gnt0) begin
            memAddr = bus.i_addr0;
        end else if (gnt1) begin
            memAddr  = bus.i_addr1;
            memWdata = bus.i_wdata1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ARB;
            rrPtr_q   <= 1'b0;
            addr_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            addr_q    <= memAddr;
            rvalid0_q <= gnt0 & ~bus.i_we0;
            rvalid1_q <= gnt1 & ~bus.i_we1;
        end
    end

    assign bus.o_gnt0           = gnt0;
    assign bus.o_gnt1           = gnt1;
    assign bus.o_mem_address    = memAddr;
    assign bus.o_mem_wr_en      = (gnt0 & bus.i_we0) | (gnt1 & bus.i_we1);
    assign bus.o_mem_write_data = memWdata;
    assign bus.o_rdata          = bus.i_mem_read_data;
    assign bus.o_rvalid0        = rvalid0_q;
    assign bus.o_rvalid1        = rvalid1_q;
    assign bus.o_owner          = state_q;
endmodule

// File: tb/tb_m10k_row_arbiter.sv
// Directed bench for m10k_row_arbiter with a behavioural 1-cycle M10K model; row r element e starts as r*8+e.
// Covers ROW_ARB_LOCK_EN when that macro is defined for the build.
module tb_m10k_row_arbiter;
    localparam int DL = 32;
    localparam int NE = 8;
    localparam int AW = 4;
    localparam int RW = DL * NE;

    logic          clk;
    logic          rstn;
    logic [RW-1:0] mem [16];
    logic [RW-1:0] readReg;
    int            compared;
    int            mismatched;

    m10k_row_arbiter_if #(.DATA_LEN(DL), .N(NE), .ADDRESS_SIZE(AW)) bus ();

    m10k_row_arbiter #(.DATA_LEN(DL), .N(NE), .ADDRESS_SIZE(AW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory: a write at edge T is visible to a read issued at edge T+1.
    always @(posedge clk) begin
        if (bus.o_mem_wr_en) mem[bus.o_mem_address] <= bus.o_mem_write_data;
        readReg <= mem[bus.o_mem_address];
    end
    assign bus.i_mem_read_data = readReg;

    function automatic logic [RW-1:0] rowOf(input int r);
        logic [RW-1:0] v;
        for (int e = 0; e < NE; e++) v[e*DL +: DL] = DL'(r * NE + e);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [RW-1:0] actual, input logic [RW-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input int a0, input logic l0,
                                 input logic r1, input logic w1, input int a1, input logic l1);
        bus.i_req0  = r0;
        bus.i_we0   = w0;
        bus.i_addr0 = AW'(a0);
        bus.i_lock0 = l0;
        bus.i_req1  = r1;
        bus.i_we1   = w1;
        bus.i_addr1 = AW'(a1);
        bus.i_lock1 = l1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [RW-1:0] a5Row;
        logic          expG0 [6];
        logic [1:0]    expOwn [6];
        int            addrSeq [4];

        compared   = 0;
        mismatched = 0;
        for (int r = 0; r < 16; r++) mem[r] = rowOf(r);
        for (int e = 0; e < NE; e++) a5Row[e*DL +: DL] = 32'hA5A5_A5A5;
        bus.i_wdata0 = '0;
        bus.i_wdata1 = '0;
        rstn = 1'b0;

        // Reset: a pending request must not be granted
        applyStimulus(1, 0, 3, 0, 1, 0, 4, 0);
        tick();
        checkOutput("rst_gnt0", RW'(bus.o_gnt0), RW'(0));
        checkOutput("rst_gnt1", RW'(bus.o_gnt1), RW'(0));
        checkOutput("rst_rvalid", RW'({bus.o_rvalid0, bus.o_rvalid1}), RW'(0));
        checkOutput("rst_wr_en", RW'(bus.o_mem_wr_en), RW'(0));
        checkOutput("rst_addr", RW'(bus.o_mem_address), RW'(0));
        checkOutput("rst_owner", RW'(bus.o_owner), RW'(0));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        tick();

        // Single read of row 3 on side 0
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0);
        checkOutput("t1_gnt0", RW'(bus.o_gnt0), RW'(1));
        checkOutput("t1_gnt1", RW'(bus.o_gnt1), RW'(0));
        checkOutput("t1_addr", RW'(bus.o_mem_address), RW'(3));
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_rvalid0", RW'(bus.o_rvalid0), RW'(1));
        checkOutput("t1_rvalid1", RW'(bus.o_rvalid1), RW'(0));
        checkOutput("t1_rdata", bus.o_rdata, rowOf(3));

        // Side-1 read of row 5 puts the pointer back on side 0
        applyStimulus(0, 0, 0, 0, 1, 0, 5, 0);
        checkOutput("t1b_gnt1", RW'(bus.o_gnt1), RW'(1));
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1b_rvalid1", RW'(bus.o_rvalid1), RW'(1));
        checkOutput("t1b_rdata", bus.o_rdata, rowOf(5));

        // Both sides reading rows 1 and 2 alternate 0,1,0,1
        addrSeq = '{1, 2, 1, 2};
        applyStimulus(1, 0, 1, 0, 1, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_gnt0_%0d", i), RW'(bus.o_gnt0), RW'(i % 2 == 0));
            checkOutput($sformatf("t2_gnt1_%0d", i), RW'(bus.o_gnt1), RW'(i % 2 == 1));
            checkOutput($sformatf("t2_addr_%0d", i), RW'(bus.o_mem_address), RW'(addrSeq[i]));
            tick();
            checkOutput($sformatf("t2_rvalid0_%0d", i), RW'(bus.o_rvalid0), RW'(i % 2 == 0));
            checkOutput($sformatf("t2_rvalid1_%0d", i), RW'(bus.o_rvalid1), RW'(i % 2 == 1));
            checkOutput($sformatf("t2_rdata_%0d", i), bus.o_rdata, rowOf(addrSeq[i]));
        end

        // Write row 9 from side 1, read it back on side 0 the very next cycle
        bus.i_wdata1 = a5Row;
        applyStimulus(0, 0, 0, 0, 1, 1, 9, 0);
        checkOutput("t3_gnt1", RW'(bus.o_gnt1), RW'(1));
        checkOutput("t3_wr_en", RW'(bus.o_mem_wr_en), RW'(1));
        checkOutput("t3_addr", RW'(bus.o_mem_address), RW'(9));
        checkOutput("t3_wdata", bus.o_mem_write_data, a5Row);
        tick();
        checkOutput("t3_no_rvalid1", RW'(bus.o_rvalid1), RW'(0));
        applyStimulus(1, 0, 9, 0, 0, 0, 0, 0);
        checkOutput("t3_gnt0", RW'(bus.o_gnt0), RW'(1));
        checkOutput("t3_rd_wr_en", RW'(bus.o_mem_wr_en), RW'(0));
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_rvalid0", RW'(bus.o_rvalid0), RW'(1));
        checkOutput("t3_rdata", bus.o_rdata, a5Row);

        // Idle cycles: no grants, no writes, address held at 9
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t4_gnt_%0d", i), RW'({bus.o_gnt0, bus.o_gnt1}), RW'(0));
            checkOutput($sformatf("t4_wr_en_%0d", i), RW'(bus.o_mem_wr_en), RW'(0));
            checkOutput($sformatf("t4_addr_%0d", i), RW'(bus.o_mem_address), RW'(9));
            tick();
            checkOutput($sformatf("t4_rvalid_%0d", i), RW'({bus.o_rvalid0, bus.o_rvalid1}), RW'(0));
        end
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 0, 0, 1, 0, 9, 0);
        checkOutput("t4_row3_kept", bus.o_rdata, rowOf(3));
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_row9_kept", bus.o_rdata, a5Row);
        checkOutput("t4_rvalid1", RW'(bus.o_rvalid1), RW'(1));

        // Lock sequence: side 0 alone with lock, then side 1 waiting, then lock dropped
`ifdef ROW_ARB_LOCK_EN
        expG0  = '{1, 1, 1, 1, 1, 0};
        expOwn = '{0, 1, 1, 1, 1, 0};
`else
        expG0  = '{1, 0, 1, 0, 1, 0};
        expOwn = '{0, 0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 4, (i < 4), (i > 0), 0, 6, 0);
            checkOutput($sformatf("t5_gnt0_%0d", i), RW'(bus.o_gnt0), RW'(expG0[i]));
            checkOutput($sformatf("t5_gnt1_%0d", i), RW'(bus.o_gnt1), RW'(!expG0[i]));
            checkOutput($sformatf("t5_owner_%0d", i), RW'(bus.o_owner), RW'(expOwn[i]));
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_owner_end", RW'(bus.o_owner), RW'(0));

        // Reset while a read is pending; pointer must return to side 0
        applyStimulus(1, 0, 2, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 1, 0, 1, 0, 2, 0);
        checkOutput("t6_pending", RW'(bus.o_rvalid0), RW'(1));
        rstn = 1'b0;
        #1;
        checkOutput("t6_rvalid0", RW'(bus.o_rvalid0), RW'(0));
        checkOutput("t6_gnt", RW'({bus.o_gnt0, bus.o_gnt1}), RW'(0));
        checkOutput("t6_addr", RW'(bus.o_mem_address), RW'(0));
        checkOutput("t6_wr_en", RW'(bus.o_mem_wr_en), RW'(0));
        tick();
        rstn = 1'b1;
        #1;
        checkOutput("t6_gnt0_after", RW'(bus.o_gnt0), RW'(1));
        checkOutput("t6_gnt1_after", RW'(bus.o_gnt1), RW'(0));
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_rvalid0_after", RW'(bus.o_rvalid0), RW'(1));
        checkOutput("t6_rdata_after", bus.o_rdata, rowOf(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
